// File: rtl/ins_sequencer_pkg.sv
// ins_sequencer_pkg: status codes shared with the decoder,
// sequencer state encoding, RAM request payload, default widths.
package ins_sequencer_pkg;

  localparam int PC_W_DEF = 16;

  localparam logic [2:0] TO_NOP       = 3'b000;
  localparam logic [2:0] TO_RAM_READ  = 3'b001;
  localparam logic [2:0] TO_ROM_READ  = 3'b010;
  localparam logic [2:0] TO_PROCESS   = 3'b011;
  localparam logic [2:0] TO_RAM_WRITE = 3'b100;
  localparam logic [2:0] NOT_DONE     = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_RAM_RD,
    S_ROM_RD,
    S_RAM_WR,
    S_EXEC,
    S_ILLEGAL
  } state_t;

  typedef struct packed {
    logic       we;
    logic [7:0] wdata;
    logic [7:0] addr;
  } ram_req_t;

  function automatic state_t dispatch(input logic [2:0] st);
    state_t s;
    unique case (st)
      TO_NOP:       s = S_FETCH;
      TO_RAM_READ:  s = S_RAM_RD;
      TO_ROM_READ:  s = S_ROM_RD;
      TO_PROCESS:   s = S_EXEC;
      TO_RAM_WRITE: s = S_RAM_WR;
      default:      s = S_ILLEGAL;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ins_sequencer_if.sv
// ins_sequencer_if: ROM and internal-RAM request/ack buses.
// master = sequencer (addr/req/wdata out), slave = memories.
interface ins_sequencer_if #(
  parameter int PC_W = ins_sequencer_pkg::PC_W_DEF
);
  logic [PC_W-1:0] rom_addr;
  logic            rom_rd;
  logic [7:0]      rom_rdata;
  logic            rom_ack;
  logic [7:0]      ram_addr;
  logic            ram_rd;
  logic            ram_wr;
  logic [7:0]      ram_wdata;
  logic [7:0]      ram_rdata;
  logic            ram_ack;

  modport master (
    output rom_addr, rom_rd,
    output ram_addr, ram_rd, ram_wr, ram_wdata,
    input  rom_rdata, rom_ack,
    input  ram_rdata, ram_ack
  );

  modport slave (
    input  rom_addr, rom_rd,
    input  ram_addr, ram_rd, ram_wr, ram_wdata,
    output rom_rdata, rom_ack,
    output ram_rdata, ram_ack
  );
endinterface

// File: rtl/ins_mem_req.sv
// ins_mem_req: request holder. i_start latches i_data and raises o_req;
// o_req drops the cycle after i_ack; o_done = ack seen while requesting.
module ins_mem_req #(
  parameter int          W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_start,
  input  logic [W-1:0] i_data,
  input  logic         i_ack,
  output logic         o_req,
  output logic [W-1:0] o_data,
  output logic         o_done
);

  logic         r_req;
  logic [W-1:0] r_data;
  logic         w_done;

  assign w_done = r_req & i_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req  <= 1'b0;
      r_data <= RST_VAL;
    end else if (i_start) begin
      r_req  <= 1'b1;
      r_data <= i_data;
    end else if (w_done) begin
      r_req  <= 1'b0;
    end
  end

  assign o_req  = r_req;
  assign o_data = r_data;
  assign o_done = w_done;

endmodule

// File: rtl/ins_sequencer.sv
// ins_sequencer: 8051 fetch/decode/operand sequencer owning PC and IR.
// Ports: clk, rst_n, bus (ROM/RAM master), ir, dec_status, rs, acc_in, opnd, exec, illegal, pc.
module ins_sequencer
  import ins_sequencer_pkg::*;
#(
  parameter int          PC_W     = PC_W_DEF,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned DEC_LAT  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  ins_sequencer_if.master bus,
  output logic [7:0]      ir,
  input  logic [2:0]      dec_status,
  input  logic [1:0]      rs,
  input  logic [7:0]      acc_in,
  output logic [7:0]      opnd,
  output logic            exec,
  output logic            illegal,
  output logic [PC_W-1:0] pc
);

  localparam logic [PC_W-1:0] PC_RST = PC_W'(RESET_PC);

  state_t          r_state;
  state_t          w_nstate;
  logic [PC_W-1:0] r_pc;
  logic [7:0]      r_ir;
  logic [7:0]      r_opnd;
  logic [7:0]      r_cnt;
  logic            w_rom_start;
  logic            w_rom_done;
  logic            w_rom_req;
  logic [PC_W-1:0] w_rom_addr;
  logic            w_ram_start;
  logic            w_ram_done;
  logic            w_ram_req;
  logic            w_ram_we;
  ram_req_t        w_ram_in;
  ram_req_t        w_ram_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    unique case (r_state)
      S_IDLE:    w_nstate = S_FETCH;
      S_FETCH:   if (w_rom_done) w_nstate = S_DECODE;
      S_DECODE:  if (r_cnt == 8'd0) w_nstate = dispatch(dec_status);
      S_RAM_RD:  if (w_ram_done) w_nstate = S_EXEC;
      S_ROM_RD:  if (w_rom_done) w_nstate = S_EXEC;
      S_RAM_WR:  if (w_ram_done) w_nstate = S_FETCH;
      S_EXEC:    w_nstate = S_FETCH;
      S_ILLEGAL: w_nstate = S_FETCH;
      default:   w_nstate = S_IDLE;
    endcase
  end

  always_comb begin
    exec    = (r_state == S_EXEC);
    illegal = (r_state == S_ILLEGAL);
  end

  // Requests are launched on the edge entering a request state,
  // so address/data are registered and stable for the whole access.
  assign w_rom_start = (w_nstate != r_state) &&
                       ((w_nstate == S_FETCH) || (w_nstate == S_ROM_RD));
  assign w_ram_start = (w_nstate != r_state) &&
                       ((w_nstate == S_RAM_RD) || (w_nstate == S_RAM_WR));
  assign w_ram_we    = (w_nstate == S_RAM_WR);

  // Rn uses ir[2:0]; @Ri reads the R0/R1 pointer selected by ir[0].
  always_comb begin
    w_ram_in       = '0;
    w_ram_in.we    = w_ram_we;
    w_ram_in.addr  = {3'b000, rs, 3'b000};
    if (w_ram_we || r_ir[3]) w_ram_in.addr[2:0] = r_ir[2:0];
    else                     w_ram_in.addr[2:0] = {2'b00, r_ir[0]};
    if (w_ram_we) w_ram_in.wdata = acc_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc   <= PC_RST;
      r_ir   <= 8'h00;
      r_opnd <= 8'h00;
      r_cnt  <= 8'd0;
    end else begin
      unique case (1'b1)
        (r_state == S_FETCH) && w_rom_done: begin
          r_ir  <= bus.rom_rdata;
          r_pc  <= r_pc + PC_W'(1);
          r_cnt <= 8'(DEC_LAT);
        end
        (r_state == S_DECODE) && (r_cnt != 8'd0): begin
          r_cnt <= r_cnt - 8'd1;
        end
        (r_state == S_ROM_RD) && w_rom_done: begin
          r_opnd <= bus.rom_rdata;
          r_pc   <= r_pc + PC_W'(1);
        end
        (r_state == S_RAM_RD) && w_ram_done: begin
          r_opnd <= bus.ram_rdata;
        end
        default: ;
      endcase
    end
  end

  ins_mem_req #(
    .W       (PC_W),
    .RST_VAL (PC_RST)
  ) u_rom (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_rom_start),
    .i_data  (r_pc),
    .i_ack   (bus.rom_ack),
    .o_req   (w_rom_req),
    .o_data  (w_rom_addr),
    .o_done  (w_rom_done)
  );

  ins_mem_req #(
    .W       ($bits(ram_req_t)),
    .RST_VAL ('0)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_ram_start),
    .i_data  (w_ram_in),
    .i_ack   (bus.ram_ack),
    .o_req   (w_ram_req),
    .o_data  (w_ram_q),
    .o_done  (w_ram_done)
  );

  assign bus.rom_addr  = w_rom_addr;
  assign bus.rom_rd    = w_rom_req;
  assign bus.ram_addr  = w_ram_q.addr;
  assign bus.ram_wdata = w_ram_q.wdata;
  assign bus.ram_rd    = w_ram_req & ~w_ram_q.we;
  assign bus.ram_wr    = w_ram_req & w_ram_q.we;

  assign ir   = r_ir;
  assign opnd = r_opnd;
  assign pc   = r_pc;

endmodule
